// File: rtl/hlen_offset_adder_if.sv
// hlen_offset_adder_if: packet-stream snoop, EX-stage offset request and header-length result bundle
interface hlen_offset_adder_if;
    logic        in_wr;
    logic        in_sop;
    logic [63:0] in_data;
    logic        in_rdy;
    logic        pkt_done;
    logic        LW_EX;
    logic        SW_EX;
    logic [63:0] Offset_EX;
    logic [63:0] HLEN_Offset_Adder_result;
    logic [5:0]  hlen_bytes;
    logic        hlen_valid;
    logic        hlen_err;

    modport master (
        output in_wr, in_sop, in_data, pkt_done, LW_EX, SW_EX, Offset_EX,
        input  in_rdy, HLEN_Offset_Adder_result, hlen_bytes, hlen_valid, hlen_err
    );

    modport slave (
        input  in_wr, in_sop, in_data, pkt_done, LW_EX, SW_EX, Offset_EX,
        output in_rdy, HLEN_Offset_Adder_result, hlen_bytes, hlen_valid, hlen_err
    );
endinterface

// File: rtl/hlen_offset_adder.sv
// hlen_offset_adder: captures IPv4 header length from packet word 1 and forms L2+IP+offset; HLEN_CHECK_EN enables IHL<5 clamp/error
module hlen_offset_adder #(
    parameter int L2_BYTES = 14
) (
    input logic                clk,
    input logic                reset,
    hlen_offset_adder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HDR, HOLD} state_t;

    state_t      state, state_nxt;
    logic        wr_sop, wr_word, capture, mem_op;
    logic [3:0]  ihl;
    logic [5:0]  hlen_q;
    logic [63:0] result_q;

    assign wr_sop  = bus.in_wr & bus.in_sop;
    assign wr_word = bus.in_wr & ~bus.in_sop;
    assign ihl     = bus.in_data[11:8];
    assign mem_op  = bus.LW_EX | bus.SW_EX;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state: release wins over a same-cycle write so a dropped packet never captures
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = wr_sop ? HDR : IDLE;
            HDR:     state_nxt = bus.pkt_done ? IDLE : wr_sop ? HDR : wr_word ? HOLD : HDR;
            HOLD:    state_nxt = bus.pkt_done ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded from state; capture is the HDR->HOLD transition
    always_comb begin
        bus.in_rdy     = (state != HOLD);
        bus.hlen_valid = (state == HOLD);
        capture        = (state == HDR) & ~bus.pkt_done & wr_word;
    end

`ifdef HLEN_CHECK_EN
    logic err_q;

    // header length capture with IHL<5 clamped to a minimal 20-byte header
    always_ff @(posedge clk) begin
        if (reset) begin
            hlen_q <= '0;
            err_q  <= 1'b0;
        end else if (capture) begin
            hlen_q <= (ihl < 4'd5) ? 6'd20 : {ihl, 2'b00};
            err_q  <= (ihl < 4'd5);
        end
    end

    assign bus.hlen_err = err_q;
`else
    // header length capture, raw IHL*4
    always_ff @(posedge clk) begin
        if (reset)        hlen_q <= '0;
        else if (capture) hlen_q <= {ihl, 2'b00};
    end

    assign bus.hlen_err = 1'b0;
`endif

    // effective offset register; uses pre-capture hlen when both happen together
    always_ff @(posedge clk) begin
        if (reset)       result_q <= '0;
        else if (mem_op) result_q <= 64'(L2_BYTES) + {58'd0, hlen_q} + bus.Offset_EX;
    end

    assign bus.hlen_bytes               = hlen_q;
    assign bus.HLEN_Offset_Adder_result = result_q;
endmodule
